pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock sequencer for the video-clock rPLL: runs on the 25 MHz board clock that feeds the PLL, pulses the PLL reset, qualifies LOCK as stable, and only then releases the CLKDIV reset and the downstream pixel/TMDS-domain reset. It retries on lock timeout, re-sequences on lock loss, and latches a fault after repeated failures.

## Interface
- PLL_RST_CYCLES, 25: cycles pll_reset is held high per attempt (1 µs).
- LOCK_STABLE_CYCLES, 2500: consecutive synced-lock-high cycles required (100 µs).
- LOCK_TIMEOUT_CYCLES, 250000: max cycles in WAIT_LOCK per attempt (10 ms).
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- RELEASE_CYCLES, 16: cycles between clkdiv_reset release and domain_reset release.
- clkin  in  1  25 MHz reference clock; sole clock.
- reset  in  1  synchronous, active-high.
- pll_lock  in  1  PLL LOCK, asynchronous; synchronised internally.
- restart  in  1  single-cycle request to re-sequence (clears retry count).
- pll_reset  out  1  to PLL RESET.
- clkdiv_reset  out  1  to CLKDIV RESETN-inverse.
- domain_reset  out  1  active-high reset for clkout domains (receiver re-synchronises).
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  $clog2(MAX_RETRIES+1)  timeouts in current sequence.
- loss_count  out  8  saturating count of lock losses after RUN/RELEASE.

## Operation
- lock_s = pll_lock through 2-FF synchroniser (2-cycle latency).
- States: PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT. All outputs are flops updated on the same edge as the state; they reflect the state being entered.
- PLL_RST: pll_reset=1, clkdiv_reset=1, domain_reset=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: pll_reset=0. stable counter +1 when lock_s=1, cleared when lock_s=0; timeout counter +1 every cycle. stable reaches LOCK_STABLE_CYCLES -> RELEASE. Else timeout reaches LOCK_TIMEOUT_CYCLES -> retry_count+1 and PLL_RST if retry_count < MAX_RETRIES, otherwise FAULT. Stable completion wins over timeout on the same cycle.
- RELEASE: clkdiv_reset=0, domain_reset=1 for RELEASE_CYCLES cycles -> RUN.
- RUN: domain_reset=0, ready=1, retry_count cleared on entry.
- lock_s=0 in RELEASE or RUN -> PLL_RST, loss_count+1 (saturates at 255), retry_count unchanged.
- FAULT: pll_reset=1, clkdiv_reset=1, domain_reset=1, fault=1; exit only by restart or reset.
- restart in any state -> PLL_RST, retry_count=0; restart has priority over lock loss and timeout. loss_count is not cleared by restart.
- Counters clear on every state transition; width = $clog2(max parameter + 1).

## Timing
- Reset values: state PLL_RST, pll_reset=1, clkdiv_reset=1, domain_reset=1, ready=0, fault=0, retry_count=0, loss_count=0, synchroniser=0, counters=0.
- Reset mid-operation: all of the above on the next edge, whatever the state.
- pll_reset is high for exactly PLL_RST_CYCLES edges after reset deasserts.
- Best case, reset release to ready: PLL_RST_CYCLES + 2 (sync) + LOCK_STABLE_CYCLES + RELEASE_CYCLES cycles, with pll_lock high from the start.
- Lock loss to domain_reset=1: 3 cycles (2 sync + 1 state edge).
- A single-cycle lock glitch in WAIT_LOCK restarts the stable count and never reaches RELEASE early.

## Structure
- Package pll_seq_pkg: state enum (pll_seq_state_t) and default parameter constants.
- Sub-module sync_2ff (1-bit 2-flop synchroniser) for pll_lock; everything else stays in one FSM module.

## Test plan
Parameters for all cases: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2, RELEASE_CYCLES=3.

- Lock high from reset release -> pll_reset high for 4 cycles; clkdiv_reset falls at cycle 14; domain_reset falls and ready rises at cycle 17.
- Lock never asserted -> three pll_reset pulses with retry_count 1 then 2; fault=1 after the third timeout; outputs held until restart.
- Lock glitch low for 1 cycle at stable count 5 -> RELEASE delayed by a full 8-cycle requalification.
- Lock drops in RUN -> domain_reset=1 and ready=0 3 cycles later, pll_reset pulse, loss_count=1, successful re-lock back to RUN.
- restart asserted on the same cycle as a lock loss in RUN -> PLL_RST with retry_count=0; loss_count not incremented.
- Synchronous reset asserted in RELEASE -> all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_seq_state_t;

  // Defaults for a 25 MHz board clock.
  localparam int unsigned DEF_PLL_RST_CYCLES      = 25;      // 1 us
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2500;    // 100 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 250000;  // 10 ms
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_RELEASE_CYCLES      = 16;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output levels for a state: {pll_reset, clkdiv_reset, domain_reset, ready, fault}.
  function automatic logic [4:0] state_outputs(input pll_seq_state_t s);
    logic [4:0] o;
    case (s)
      ST_PLL_RST:   o = 5'b11100;
      ST_WAIT_LOCK: o = 5'b01100;
      ST_RELEASE:   o = 5'b00100;
      ST_RUN:       o = 5'b00010;
      ST_FAULT:     o = 5'b11101;
      default:      o = 5'b11100;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with a synchronous clear.
module sync_2ff (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input; clear forces both stages low.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Pulses the PLL reset, qualifies LOCK as stable, then releases the CLKDIV
// reset followed by the clkout-domain reset. Retries on lock timeout,
// re-sequences on lock loss and latches FAULT after repeated timeouts.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned RELEASE_CYCLES      = DEF_RELEASE_CYCLES
) (
  input  logic                               clkin,
  input  logic                               reset,
  input  logic                               pll_lock,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               clkdiv_reset,
  output logic                               domain_reset,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [7:0]                         loss_count,
  output logic [2:0]                         dbg_state
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                    RELEASE_CYCLES) + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(RELEASE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  pll_seq_state_t r_state, w_state_next;
  logic [TW-1:0]  r_timer, w_timer_next;
  logic [SW-1:0]  r_stable, w_stable_next;
  logic [RW-1:0]  r_retry, w_retry_next;
  logic [7:0]     r_loss, w_loss_next;
  logic           r_pll_reset, r_clkdiv_reset, r_domain_reset, r_ready, r_fault;
  logic           w_lock_s;
  logic           w_sync_clr;
  logic           w_transition;

  // LOCK means nothing while the PLL is held in reset, so the synchroniser is
  // cleared then; every attempt therefore sees the full 2-cycle sync latency.
  assign w_sync_clr = reset | r_pll_reset;

  sync_2ff u_lock_sync (
    .i_clk (clkin),
    .i_clr (w_sync_clr),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  // Next state, counters and retry/loss bookkeeping; restart overrides all.
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_loss_next  = r_loss;
    if (restart) begin
      w_state_next = ST_PLL_RST;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_timer == PLL_RST_LAST) w_state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s && (r_stable == STABLE_LAST)) begin
            w_state_next = ST_RELEASE;
          end else if (r_timer == TIMEOUT_LAST) begin
            if (r_retry < RETRY_LIMIT) begin
              w_retry_next = r_retry + RW'(1);
              w_state_next = ST_PLL_RST;
            end else begin
              w_state_next = ST_FAULT;
            end
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!w_lock_s) begin
            w_state_next = ST_PLL_RST;
            if (r_loss != 8'hFF) w_loss_next = r_loss + 8'd1;
          end else if ((r_state == ST_RELEASE) && (r_timer == RELEASE_LAST)) begin
            w_state_next = ST_RUN;
            w_retry_next = '0;
          end
        end
        ST_FAULT: begin
          w_state_next = ST_FAULT;
        end
        default: begin
          w_state_next = ST_PLL_RST;
        end
      endcase
    end

    w_transition = restart || (w_state_next != r_state);

    w_timer_next = '0;
    if (!w_transition && ((r_state == ST_PLL_RST) || (r_state == ST_WAIT_LOCK) ||
                          (r_state == ST_RELEASE)))
      w_timer_next = r_timer + TW'(1);

    w_stable_next = '0;
    if (!w_transition && (r_state == ST_WAIT_LOCK) && w_lock_s)
      w_stable_next = r_stable + SW'(1);
  end

  // State, counters and registered outputs all update on the same edge.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state  <= ST_PLL_RST;
      r_timer  <= '0;
      r_stable <= '0;
      r_retry  <= '0;
      r_loss   <= '0;
      {r_pll_reset, r_clkdiv_reset, r_domain_reset, r_ready, r_fault}
               <= state_outputs(ST_PLL_RST);
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_stable <= w_stable_next;
      r_retry  <= w_retry_next;
      r_loss   <= w_loss_next;
      {r_pll_reset, r_clkdiv_reset, r_domain_reset, r_ready, r_fault}
               <= state_outputs(w_state_next);
    end
  end

  assign pll_reset    = r_pll_reset;
  assign clkdiv_reset = r_clkdiv_reset;
  assign domain_reset = r_domain_reset;
  assign ready        = r_ready;
  assign fault        = r_fault;
  assign retry_count  = r_retry;
  assign loss_count   = r_loss;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with small timing parameters. Edge k is the
// k-th rising edge after the last edge that sampled reset high (edge 0).
module tb_pll_lock_sequencer;

  localparam int W = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, clkdiv_reset, domain_reset, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] dbg_state;
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .MAX_RETRIES         (2),
    .RELEASE_CYCLES      (3)
  ) dut (
    .clkin        (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .restart      (restart),
    .pll_reset    (pll_reset),
    .clkdiv_reset (clkdiv_reset),
    .domain_reset (domain_reset),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .loss_count   (loss_count),
    .dbg_state    (dbg_state)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  assign obs = {pll_reset, clkdiv_reset, domain_reset, ready, fault, retry_count, loss_count};

  function automatic logic [W-1:0] pack(input logic pr, input logic cr, input logic dr,
                                        input logic rd, input logic ft,
                                        input logic [1:0] rc, input logic [7:0] lc);
    return {pr, cr, dr, rd, ft, rc, lc};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset held with random lock/restart activity: outputs stay at reset values.
  task automatic test_reset();
    logic [W-1:0] e;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pll_lock = 1'($urandom_range(0, 1));
      restart  = 1'($urandom_range(0, 1));
      exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
      step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset i=%0d got=%h exp=%h", i, obs, e);
      end
    end
    restart = 1'b0;
  endtask

  // Lock high from reset release: clkdiv falls at 14, ready at 17.
  task automatic test_best_case();
    logic [W-1:0] e;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(pack(k < 4, k < 14, k < 17, k >= 17, 1'b0, 2'd0, 8'd0));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL best_case k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  // Lock never asserted: three 68-cycle attempts, then FAULT until restart at 231.
  task automatic test_timeout_fault();
    logic [W-1:0] e;
    pll_lock = 1'b0;
    do_reset();
    for (int k = 0; k <= 240; k++) begin
      restart = (k == 231);
      if (k < 204)
        exp_q.push_back(pack((k % 68) < 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'(k / 68), 8'd0));
      else if (k < 231)
        exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd0));
      else
        exp_q.push_back(pack((k - 231) < 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL timeout_fault k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    restart = 1'b0;
  endtask

  // One-cycle lock drop seen after stable count 5: requalification ends at 20.
  task automatic test_glitch();
    logic [W-1:0] e;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      pll_lock = (k != 10);
      exp_q.push_back(pack(k < 4, k < 20, k < 23, k >= 23, 1'b0, 2'd0, 8'd0));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  // Lock lost in RUN (edges 21-24), re-lock, then restart keeps loss_count.
  task automatic test_lock_loss();
    logic [W-1:0] e;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      pll_lock = !(k >= 21 && k <= 24);
      restart  = (k == 44);
      if (k < 23)
        exp_q.push_back(pack(k < 4, k < 14, k < 17, k >= 17, 1'b0, 2'd0, 8'd0));
      else if (k < 44)
        exp_q.push_back(pack(k < 27, k < 37, k < 40, k >= 40, 1'b0, 2'd0, 8'd1));
      else
        exp_q.push_back(pack(k < 48, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL lock_loss k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    restart = 1'b0;
  endtask

  // Restart on the same edge as a lock loss in RUN: no loss is counted.
  task automatic test_restart_vs_loss();
    logic [W-1:0] e;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k <= 42; k++) begin
      pll_lock = !(k >= 21 && k <= 24);
      restart  = (k == 23);
      if (k < 23)
        exp_q.push_back(pack(k < 4, k < 14, k < 17, k >= 17, 1'b0, 2'd0, 8'd0));
      else
        exp_q.push_back(pack(k < 27, k < 37, k < 40, k >= 40, 1'b0, 2'd0, 8'd0));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL restart_vs_loss k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    restart = 1'b0;
  endtask

  // Loss then re-lock, reset sampled at edge 38 while in RELEASE.
  task automatic test_reset_in_release();
    logic [W-1:0] e;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k <= 46; k++) begin
      pll_lock = (k != 21);
      reset    = (k == 38);
      if (k < 23)
        exp_q.push_back(pack(k < 4, k < 14, k < 17, k >= 17, 1'b0, 2'd0, 8'd0));
      else if (k < 38)
        exp_q.push_back(pack(k < 27, k < 37, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
      else
        exp_q.push_back(pack((k - 38) < 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
      if (k > 0) step();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_in_release k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    reset = 1'b0;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_best_case();
    test_timeout_fault();
    test_glitch();
    test_lock_loss();
    test_restart_vs_loss();
    test_reset_in_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
